packet_parser_arbiter: RTL and testbench

//  Round-robin arbiter sharing one packet_parser instance between NUM_REQ packet sources.

---
 rtl/packet_parser_arbiter.sv | 150 +++++++++++++++
 tb/tb_packet_parser_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_parser_arbiter.sv
// Round-robin arbiter that shares one packet parser between NUM_REQ packet sources.
// Grants only at packet boundaries and forces an idle gap after every packet end.
module packet_parser_arbiter #(
   parameter int NUM_REQ          = 4,
   parameter int WIDTH_DATA_BYTES = 8,
   parameter int GAP_CYCLES       = 2,
   localparam int WIDTH_ID        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int WDB             = WIDTH_DATA_BYTES
) (
   input  logic                       clk_host,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_sop,
   input  logic [NUM_REQ-1:0]         req_eop,
   input  logic [NUM_REQ*WDB-1:0]     req_byteen,
   input  logic [NUM_REQ*WDB*8-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       bus_out_valid,
   output logic                       bus_out_sop,
   output logic                       bus_out_eop,
   output logic [WDB-1:0]             bus_out_byteen,
   output logic [WDB*8-1:0]           bus_out_data,
   output logic [WIDTH_ID-1:0]        grant_id,
   output logic                       busy,
   output logic                       pkt_done,
   output logic                       err_bubble
);

   localparam int WIDTH_GAP = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [WIDTH_GAP-1:0] GAP_INIT = WIDTH_GAP'(GAP_CYCLES - 1);
   localparam logic [WIDTH_ID-1:0]  PTR_INIT = WIDTH_ID'(NUM_REQ - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} state_t;

   state_t                 state_reg;
   logic [WIDTH_ID-1:0]    grant_id_reg;
   logic [WIDTH_ID-1:0]    ptr_reg;
   logic [WIDTH_GAP-1:0]   gap_cnt_reg;
   logic [NUM_REQ-1:0]     ready_reg;
   logic                   out_valid_reg;
   logic                   out_sop_reg;
   logic                   out_eop_reg;
   logic [WDB-1:0]         out_byteen_reg;
   logic [WDB*8-1:0]       out_data_reg;
   logic                   pkt_done_reg;
   logic                   err_bubble_reg;

   logic [WDB-1:0]         byteen_arr [NUM_REQ];
   logic [WDB*8-1:0]       data_arr   [NUM_REQ];
   logic [NUM_REQ-1:0]     cand;
   logic                   win_found;
   logic [WIDTH_ID-1:0]    win_id;
   logic [WIDTH_ID-1:0]    idx_w;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign byteen_arr[gi] = req_byteen[gi*WDB +: WDB];
         assign data_arr[gi]   = req_data[gi*WDB*8 +: WDB*8];
      end
   endgenerate

   // Only a beat carrying SOP can win; valid-without-SOP stalls forever in IDLE.
   assign cand = req_valid & req_sop;

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx_w     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_w = WIDTH_ID'((int'(ptr_reg) + k) % NUM_REQ);
         if (!win_found && cand[idx_w]) begin
            win_found = 1'b1;
            win_id    = idx_w;
         end
      end
   end

   always_ff @(posedge clk_host) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         grant_id_reg   <= '0;
         ptr_reg        <= PTR_INIT;
         gap_cnt_reg    <= '0;
         ready_reg      <= '0;
         out_valid_reg  <= 1'b0;
         out_sop_reg    <= 1'b0;
         out_eop_reg    <= 1'b0;
         out_byteen_reg <= '0;
         out_data_reg   <= '0;
         pkt_done_reg   <= 1'b0;
         err_bubble_reg <= 1'b0;
      end else begin
         out_valid_reg  <= 1'b0;
         out_sop_reg    <= 1'b0;
         out_eop_reg    <= 1'b0;
         out_byteen_reg <= '0;
         out_data_reg   <= '0;
         pkt_done_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (win_found) begin
                  grant_id_reg <= win_id;
                  ptr_reg      <= win_id;
                  ready_reg    <= NUM_REQ'(1) << win_id;
                  state_reg    <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (req_valid[grant_id_reg]) begin
                  out_valid_reg  <= 1'b1;
                  out_sop_reg    <= req_sop[grant_id_reg];
                  out_eop_reg    <= req_eop[grant_id_reg];
                  out_byteen_reg <= byteen_arr[grant_id_reg];
                  out_data_reg   <= data_arr[grant_id_reg];
                  if (req_eop[grant_id_reg]) begin
                     pkt_done_reg <= 1'b1;
                     ready_reg    <= '0;
                     gap_cnt_reg  <= GAP_INIT;
                     state_reg    <= ST_GAP;
                  end
               end else begin
                  // A hole inside a packet would be misparsed, so flag it permanently.
                  err_bubble_reg <= 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign req_ready      = ready_reg;
   assign bus_out_valid  = out_valid_reg;
   assign bus_out_sop    = out_sop_reg;
   assign bus_out_eop    = out_eop_reg;
   assign bus_out_byteen = out_byteen_reg;
   assign bus_out_data   = out_data_reg;
   assign grant_id       = grant_id_reg;
   assign busy           = (state_reg != ST_IDLE);
   assign pkt_done       = pkt_done_reg;
   assign err_bubble     = err_bubble_reg;

endmodule

// File: tb/tb_packet_parser_arbiter.sv
// Directed bench for packet_parser_arbiter: four requesters, 8-byte beats, 2-cycle gap.
module tb_packet_parser_arbiter;

   localparam int NREQ = 4;
   localparam int GAP  = 2;

   logic               clk_host = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_sop;
   logic [NREQ-1:0]    req_eop;
   logic [NREQ*8-1:0]  req_byteen;
   logic [NREQ*64-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               bus_out_valid;
   logic               bus_out_sop;
   logic               bus_out_eop;
   logic [7:0]         bus_out_byteen;
   logic [63:0]        bus_out_data;
   logic [1:0]         grant_id;
   logic               busy;
   logic               pkt_done;
   logic               err_bubble;

   int n_checks = 0;
   int n_fail   = 0;

   packet_parser_arbiter #(
      .NUM_REQ(NREQ), .WIDTH_DATA_BYTES(8), .GAP_CYCLES(GAP)
   ) dut (
      .clk_host(clk_host), .rst(rst),
      .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
      .req_byteen(req_byteen), .req_data(req_data), .req_ready(req_ready),
      .bus_out_valid(bus_out_valid), .bus_out_sop(bus_out_sop), .bus_out_eop(bus_out_eop),
      .bus_out_byteen(bus_out_byteen), .bus_out_data(bus_out_data),
      .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done), .err_bubble(err_bubble)
   );

   always #5 clk_host = ~clk_host;

   always @(negedge clk_host) begin
      if (bus_out_valid)
         $display("beat grant=%0d sop=%b eop=%b be=%h data=%h done=%b",
                  grant_id, bus_out_sop, bus_out_eop, bus_out_byteen, bus_out_data, pkt_done);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_host);
      #1;
   endtask

   task automatic set_beat(input int i, input logic v, input logic s, input logic e,
                           input logic [7:0] be, input logic [63:0] d);
      req_valid[i]          = v;
      req_sop[i]            = s;
      req_eop[i]            = e;
      req_byteen[i*8 +: 8]  = be;
      req_data[i*64 +: 64]  = d;
   endtask

   function automatic logic [63:0] pat(input int i);
      return 64'hA5A5_0000_0000_0000 | 64'(i);
   endfunction

   int          cyc;
   int          nb;
   int          last_cyc;
   logic [1:0]  exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_sop = '0; req_eop = '0; req_byteen = '0; req_data = '0;
      tick(); tick();
      check_eq("rst_valid", bus_out_valid, 1'b0);
      check_eq("rst_ready", req_ready, 4'b0000);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_grant", grant_id, 2'd0);
      check_eq("rst_err", err_bubble, 1'b0);
      check_eq("rst_data", bus_out_data, 64'h0);
      rst = 1'b0;

      // 1: three-beat packet from requester 0
      set_beat(0, 1, 1, 0, 8'hFF, 64'h1111_1111_1111_1111);
      tick();
      check_eq("t1_ready", req_ready, 4'b0001);
      check_eq("t1_busy", busy, 1'b1);
      check_eq("t1_nolat", bus_out_valid, 1'b0);
      tick();
      check_eq("t1_b0_valid", bus_out_valid, 1'b1);
      check_eq("t1_b0_sop", bus_out_sop, 1'b1);
      check_eq("t1_b0_data", bus_out_data, 64'h1111_1111_1111_1111);
      set_beat(0, 1, 0, 0, 8'hFF, 64'h2222_2222_2222_2222);
      tick();
      check_eq("t1_b1_sop", bus_out_sop, 1'b0);
      check_eq("t1_b1_data", bus_out_data, 64'h2222_2222_2222_2222);
      set_beat(0, 1, 0, 1, 8'hFF, 64'h3333_3333_3333_3333);
      tick();
      check_eq("t1_b2_data", bus_out_data, 64'h3333_3333_3333_3333);
      check_eq("t1_b2_eop", bus_out_eop, 1'b1);
      check_eq("t1_done", pkt_done, 1'b1);
      check_eq("t1_ready_off", req_ready, 4'b0000);
      set_beat(0, 0, 0, 0, 8'h00, 64'h0);
      tick();
      check_eq("t1_gap_valid", bus_out_valid, 1'b0);
      check_eq("t1_gap_data", bus_out_data, 64'h0);
      check_eq("t1_gap_busy", busy, 1'b1);
      check_eq("t1_done_pulse", pkt_done, 1'b0);
      tick();
      check_eq("t1_idle", busy, 1'b0);

      // 2: all requesters hold one-beat packets from reset
      for (int i = 0; i < NREQ; i++) set_beat(i, 1, 1, 1, 8'hFF, pat(i));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0; nb = 0; last_cyc = 0;
      while (nb < 5 && cyc < 60) begin
         tick();
         cyc++;
         if (bus_out_valid) begin
            check_eq($sformatf("t2_grant%0d", nb), grant_id, exp_order[nb]);
            check_eq($sformatf("t2_data%0d", nb), bus_out_data, pat(int'(exp_order[nb])));
            if (nb == 0) check_eq("t2_first_at", cyc, 2);
            else check_eq($sformatf("t2_space%0d", nb), cyc - last_cyc, GAP + 2);
            last_cyc = cyc;
            nb++;
            if (nb == 5) begin
               req_valid = '0; req_sop = '0; req_eop = '0;
            end
         end
      end
      check_eq("t2_count", nb, 5);
      req_valid = '0; req_sop = '0; req_eop = '0;
      tick(); tick(); tick(); tick();
      check_eq("t2_idle", busy, 1'b0);
      check_eq("t2_err", err_bubble, 1'b0);

      // 3: one-beat packet from requester 2 with partial byte enables
      set_beat(2, 1, 1, 1, 8'h0F, 64'h0000_0000_C3C3_C3C3);
      tick();
      check_eq("t3_ready", req_ready, 4'b0100);
      tick();
      check_eq("t3_valid", bus_out_valid, 1'b1);
      check_eq("t3_sopeop", {bus_out_sop, bus_out_eop}, 2'b11);
      check_eq("t3_byteen", bus_out_byteen, 8'h0F);
      check_eq("t3_data", bus_out_data, 64'h0000_0000_C3C3_C3C3);
      check_eq("t3_done", pkt_done, 1'b1);
      check_eq("t3_grant", grant_id, 2'd2);
      set_beat(2, 0, 0, 0, 8'h00, 64'h0);
      tick();
      check_eq("t3_gap_valid", bus_out_valid, 1'b0);
      check_eq("t3_gap_be", bus_out_byteen, 8'h00);
      check_eq("t3_gap_busy", busy, 1'b1);
      tick();
      check_eq("t3_idle", busy, 1'b0);

      // 4: requester 1 drops valid on beat 2 of 4
      set_beat(1, 1, 1, 0, 8'hFF, 64'hB1);
      tick();
      check_eq("t4_ready", req_ready, 4'b0010);
      tick();
      check_eq("t4_b0", bus_out_data, 64'hB1);
      set_beat(1, 0, 0, 0, 8'hFF, 64'hB2);
      tick();
      check_eq("t4_bubble_valid", bus_out_valid, 1'b0);
      check_eq("t4_bubble_data", bus_out_data, 64'h0);
      check_eq("t4_err", err_bubble, 1'b1);
      set_beat(1, 1, 0, 0, 8'hFF, 64'hB2);
      tick();
      check_eq("t4_b1", bus_out_data, 64'hB2);
      set_beat(1, 1, 0, 0, 8'hFF, 64'hB3);
      tick();
      check_eq("t4_b2", bus_out_data, 64'hB3);
      set_beat(1, 1, 0, 1, 8'hFF, 64'hB4);
      tick();
      check_eq("t4_b3", bus_out_data, 64'hB4);
      check_eq("t4_done", pkt_done, 1'b1);
      set_beat(1, 0, 0, 0, 8'h00, 64'h0);
      tick(); tick(); tick();
      check_eq("t4_err_sticky", err_bubble, 1'b1);
      check_eq("t4_idle", busy, 1'b0);

      // 5: reset during beat 2 of 5, then a fresh packet from requester 1
      set_beat(0, 1, 1, 0, 8'hFF, 64'hD0);
      tick();
      check_eq("t5_ready", req_ready, 4'b0001);
      tick();
      check_eq("t5_b0", bus_out_data, 64'hD0);
      set_beat(0, 1, 0, 0, 8'hFF, 64'hD1);
      rst = 1'b1;
      tick();
      check_eq("t5_rst_valid", bus_out_valid, 1'b0);
      check_eq("t5_rst_data", bus_out_data, 64'h0);
      check_eq("t5_rst_busy", busy, 1'b0);
      check_eq("t5_rst_err", err_bubble, 1'b0);
      check_eq("t5_rst_ready", req_ready, 4'b0000);
      check_eq("t5_rst_grant", grant_id, 2'd0);
      rst = 1'b0;
      set_beat(0, 0, 0, 0, 8'h00, 64'h0);
      set_beat(1, 1, 1, 1, 8'hFF, 64'h5151);
      tick();
      check_eq("t5_new_ready", req_ready, 4'b0010);
      check_eq("t5_new_grant", grant_id, 2'd1);
      tick();
      check_eq("t5_new_beat", {bus_out_valid, bus_out_sop, bus_out_eop}, 3'b111);
      check_eq("t5_new_data", bus_out_data, 64'h5151);
      set_beat(1, 0, 0, 0, 8'h00, 64'h0);
      tick(); tick(); tick();
      check_eq("t5_idle", busy, 1'b0);

      // 6: requester 3 valid without SOP never wins against requester 1
      set_beat(3, 1, 0, 0, 8'hFF, 64'hDEAD);
      set_beat(1, 1, 1, 0, 8'hFF, 64'hE0);
      tick();
      check_eq("t6_ready", req_ready, 4'b0010);
      tick();
      check_eq("t6_b0", bus_out_data, 64'hE0);
      check_eq("t6_grant", grant_id, 2'd1);
      set_beat(1, 1, 0, 1, 8'hFF, 64'hE1);
      tick();
      check_eq("t6_b1", bus_out_data, 64'hE1);
      check_eq("t6_eop", bus_out_eop, 1'b1);
      set_beat(1, 0, 0, 0, 8'h00, 64'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq($sformatf("t6_stall_ready%0d", k), req_ready, 4'b0000);
      end
      check_eq("t6_idle", busy, 1'b0);
      check_eq("t6_no_out", bus_out_valid, 1'b0);
      set_beat(3, 0, 0, 0, 8'h00, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
